// File: rtl/main_ctrl_fsm_if.sv
// rtl/main_ctrl_fsm_if.sv - control bus between main_ctrl_fsm and the datapath/memories
interface main_ctrl_fsm_if #(
    parameter int RET_W = 16
);
    logic [3:0]       fetch_opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             alu_zero;
    logic             imem_req;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic [1:0]       alu_op;
    logic [3:0]       opcode;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_we;
    logic             mem_to_reg;
    logic             illegal_op;
    logic             retire;
    logic [RET_W-1:0] retired_cnt;

    modport master (
        input  fetch_opcode, imem_ready, dmem_ready, alu_zero,
        output imem_req, ir_we, pc_we, pc_src, alu_op, opcode,
               dmem_req, dmem_we, reg_we, mem_to_reg, illegal_op,
               retire, retired_cnt
    );

    modport slave (
        output fetch_opcode, imem_ready, dmem_ready, alu_zero,
        input  imem_req, ir_we, pc_we, pc_src, alu_op, opcode,
               dmem_req, dmem_we, reg_we, mem_to_reg, illegal_op,
               retire, retired_cnt
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// rtl/main_ctrl_fsm.sv - multi-cycle main control FSM for the 16-bit core
module main_ctrl_fsm #(
    parameter int RET_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    main_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [RET_W-1:0] cnt_q;

    logic       imem_req_c, ir_we_c, pc_we_c, dmem_req_c, dmem_we_c;
    logic       reg_we_c, mem_to_reg_c, illegal_c, retire_c;
    logic [1:0] pc_src_c, alu_op_c;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_data_op(input logic [3:0] op);
        return (op >= 4'b0010) && (op <= 4'b1001);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

    // Strobes decode from state and latched opcode; only the ready/zero inputs
    // of the waiting state qualify them.
    always_comb begin
        imem_req_c   = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'b00;
        alu_op_c     = 2'b00;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        reg_we_c     = 1'b0;
        mem_to_reg_c = 1'b0;
        illegal_c    = 1'b0;
        retire_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                end
            end
            S_DECODE: illegal_c = is_illegal(op_q);
            S_EXEC: begin
                if (is_mem_op(op_q)) begin
                    alu_op_c = 2'b10;
                end else if ((op_q == OP_BEQ) || (op_q == OP_BNE)) begin
                    alu_op_c = 2'b01;
                    pc_src_c = 2'b01;
                    pc_we_c  = (op_q == OP_BEQ) ? bus.alu_zero : ~bus.alu_zero;
                    retire_c = 1'b1;
                end else if (op_q == OP_JMP) begin
                    pc_src_c = 2'b10;
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op_q == OP_ST);
                retire_c   = bus.dmem_ready && (op_q == OP_ST);
            end
            S_WB: begin
                reg_we_c     = 1'b1;
                mem_to_reg_c = (op_q == OP_LD);
                retire_c     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            if (retire_c)
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        op_q    <= bus.fetch_opcode;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= is_illegal(op_q) ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    if (is_mem_op(op_q))
                        state_q <= S_MEM;
                    else if (is_data_op(op_q))
                        state_q <= S_WB;
                    else
                        state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (bus.dmem_ready)
                        state_q <= (op_q == OP_LD) ? S_WB : S_FETCH;
                end
                S_WB: state_q <= S_FETCH;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req    = imem_req_c;
    assign bus.ir_we       = ir_we_c;
    assign bus.pc_we       = pc_we_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.alu_op      = alu_op_c;
    assign bus.opcode      = op_q;
    assign bus.dmem_req    = dmem_req_c;
    assign bus.dmem_we     = dmem_we_c;
    assign bus.reg_we      = reg_we_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.illegal_op  = illegal_c;
    assign bus.retire      = retire_c;
    assign bus.retired_cnt = cnt_q;
endmodule
